// File: rtl/switch_order_pkg.sv
// Shared constants and FSM state type for the switch/order column controller.
package switch_order_pkg;

   localparam int NCOL  = 45;   // columns per 360-bit row
   localparam int NBANK = 8;    // banks in the row RAM (one per rotation step)
   localparam int COL_W = 6;    // width of a column index 0..44
   localparam int ORD_W = 3;    // width of a rotation 0..7

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WAIT = 2'd2,
      ST_RUN  = 2'd3
   } state_e;

endpackage

// File: rtl/switch_order_ctrl.sv
// Row/column sequencer for the switch/order datapath.
// For each row of a frame: one RAM read strobe, RAM_LAT wait cycles, then
// 45 column selects with a per-row rotation (rot_offset + row) mod 8.
// Everything advances only on fs_en. frame_abort beats every other input.
// Optional status outputs (start_err, frame_cnt) are built only when the
// macro SWITCH_ORDER_CTRL_STATUS_EN is defined.
module switch_order_ctrl
   import switch_order_pkg::*;
#(
   parameter int RAM_LAT = 1,   // RAM read latency in fs_en cycles, 1..3
   parameter int ROW_W   = 8
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             fs_en,
   input  logic             frame_start,
   input  logic [ROW_W-1:0] frame_rows,
   input  logic [2:0]       rot_offset,
   input  logic             frame_abort,
   output logic             ram_rd_en,
   output logic [ROW_W-1:0] ram_rd_addr,
   output logic             switch_vld,
   output logic [COL_W-1:0] switch_array,
   output logic [ORD_W-1:0] order_array,
   output logic             busy,
   output logic             frame_done
`ifdef SWITCH_ORDER_CTRL_STATUS_EN
   ,
   output logic             start_err,
   output logic [15:0]      frame_cnt
`endif
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOL - 1);
   localparam logic [1:0]       LAT_LAST = 2'(RAM_LAT - 1);

   state_e             state_q;
   logic [ROW_W-1:0]   row_q;
   logic [ROW_W-1:0]   rows_q;
   logic [1:0]         wait_q;
   logic [COL_W-1:0]   col_q;
   logic [ORD_W-1:0]   order_q;
   logic [ROW_W-1:0]   addr_q;
   logic               rd_en_q;
   logic               vld_q;
   logic               busy_q;
   logic               done_q;

   logic               last_col;
   logic               last_row;
   logic               done_set;

   assign last_col = (col_q == COL_LAST);
   // rows_q is never zero outside IDLE, so the subtraction cannot wrap.
   assign last_row = (row_q == rows_q - 1'b1);

   // A frame ends either on an empty-frame start or after the last column of
   // the last row; an abort on the same enabled cycle suppresses it.
   assign done_set = fs_en && !frame_abort &&
                     (((state_q == ST_IDLE) && frame_start && (frame_rows == '0)) ||
                      ((state_q == ST_RUN) && last_col && last_row));

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         rows_q  <= '0;
         wait_q  <= '0;
         col_q   <= '0;
         order_q <= '0;
         addr_q  <= '0;
         rd_en_q <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (fs_en) begin
         rd_en_q <= 1'b0;
         done_q  <= done_set;
         if (frame_abort) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            wait_q  <= '0;
            col_q   <= '0;
            order_q <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (frame_start) begin
                     rows_q <= frame_rows;
                     if (frame_rows != '0) begin
                        state_q <= ST_RD;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        row_q   <= '0;
                        addr_q  <= '0;
                        order_q <= rot_offset;
                     end
                  end
               end
               ST_RD: begin
                  state_q <= ST_WAIT;
                  wait_q  <= '0;
               end
               ST_WAIT: begin
                  if (wait_q == LAT_LAST) begin
                     state_q <= ST_RUN;
                     vld_q   <= 1'b1;
                     col_q   <= '0;
                  end else begin
                     wait_q <= wait_q + 1'b1;
                  end
               end
               ST_RUN: begin
                  if (last_col) begin
                     vld_q <= 1'b0;
                     col_q <= '0;
                     if (last_row) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        row_q   <= '0;
                        addr_q  <= '0;
                        order_q <= '0;
                     end else begin
                        state_q <= ST_RD;
                        rd_en_q <= 1'b1;
                        row_q   <= row_q + 1'b1;
                        addr_q  <= row_q + 1'b1;
                        order_q <= order_q + 1'b1;   // wraps 7 -> 0
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign ram_rd_en    = rd_en_q;
   assign ram_rd_addr  = addr_q;
   assign switch_vld   = vld_q;
   assign switch_array = col_q;
   assign order_array  = order_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;

`ifdef SWITCH_ORDER_CTRL_STATUS_EN
   logic        start_err_q;
   logic [15:0] frame_cnt_q;

   // Sticky flag for starts issued while busy, and a wrapping frame counter.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         start_err_q <= 1'b0;
         frame_cnt_q <= '0;
      end else if (fs_en) begin
         if (frame_start && busy_q) begin
            start_err_q <= 1'b1;
         end
         if (done_set) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end

   assign start_err = start_err_q;
   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_switch_order_ctrl.sv
// Self-checking bench for switch_order_ctrl (RAM_LAT=1, ROW_W=8).
// Status outputs are checked when SWITCH_ORDER_CTRL_STATUS_EN is defined.
module tb_switch_order_ctrl;

   localparam int LAT  = 1;
   localparam int NC   = 45;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fs_en;
   logic       frame_start;
   logic [7:0] frame_rows;
   logic [2:0] rot_offset;
   logic       frame_abort;
   logic       ram_rd_en;
   logic [7:0] ram_rd_addr;
   logic       switch_vld;
   logic [5:0] switch_array;
   logic [2:0] order_array;
   logic       busy;
   logic       frame_done;
`ifdef SWITCH_ORDER_CTRL_STATUS_EN
   logic        start_err;
   logic [15:0] frame_cnt;
`endif

   always #5 clk = ~clk;

   switch_order_ctrl #(.RAM_LAT(LAT), .ROW_W(8)) dut (
      .sys_clk      (clk),
      .rst_n        (rst_n),
      .fs_en        (fs_en),
      .frame_start  (frame_start),
      .frame_rows   (frame_rows),
      .rot_offset   (rot_offset),
      .frame_abort  (frame_abort),
      .ram_rd_en    (ram_rd_en),
      .ram_rd_addr  (ram_rd_addr),
      .switch_vld   (switch_vld),
      .switch_array (switch_array),
      .order_array  (order_array),
      .busy         (busy),
      .frame_done   (frame_done)
`ifdef SWITCH_ORDER_CTRL_STATUS_EN
      ,
      .start_err    (start_err),
      .frame_cnt    (frame_cnt)
`endif
   );

   typedef struct packed {
      logic       rd;
      logic [7:0] addr;
      logic       vld;
      logic [5:0] col;
      logic [2:0] ord;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      int rows; int rot; int mode; int abort_idx; bit spur;
      int exp_rd; int exp_vld; int exp_dur; int exp_clk; int exp_done;
   } vec_t;

   int tests = 0;
   int fails = 0;
   bit err_exp = 1'b0;
   int cnt_exp = 0;

   function automatic obs_t snap();
      obs_t o;
      o.rd = ram_rd_en; o.addr = ram_rd_addr; o.vld = switch_vld;
      o.col = switch_array; o.ord = order_array; o.busy = busy; o.done = frame_done;
      return o;
   endfunction

   // Control bits always matter; address only with a read, column/rotation only when valid.
   function automatic bit match(obs_t a, obs_t e);
      bit ok;
      ok = (a.rd == e.rd) && (a.vld == e.vld) && (a.busy == e.busy) && (a.done == e.done);
      if (e.rd)  ok = ok && (a.addr == e.addr);
      if (e.vld) ok = ok && (a.col == e.col) && (a.ord == e.ord);
      return ok;
   endfunction

   task automatic check(input string name, input int idx, input bit ok,
                        input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (!ok) begin
         fails++;
         if (fails <= 40)
            $display("[TB] FAIL %s idx=%0d got=0x%0h expected=0x%0h", name, idx, got, exp);
      end
   endtask

   task automatic step(input bit en);
      fs_en = en;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_status(input string name);
`ifdef SWITCH_ORDER_CTRL_STATUS_EN
      check({name, "_start_err"}, 0, start_err == err_exp, 32'(start_err), 32'(err_exp));
      check({name, "_frame_cnt"}, 0, frame_cnt == 16'(cnt_exp), 32'(frame_cnt), 32'(cnt_exp));
`endif
   endtask

   // mode: 0 = fs_en always high, 1 = every other cycle, 2 = random.
   task automatic run_frame(input int rows, input int rot, input int mode, input int abort_idx,
                            input bit spur, output int n_rd, output int n_vld,
                            output int dur, output int clk_dur, output int n_done);
      obs_t q[$];
      obs_t e, cur, prev;
      int idx, clks;
      bit en;
      // Expected observation after every enabled edge, starting at the accept edge.
      if (rows == 0) begin
         e = '0; e.done = 1'b1; q.push_back(e);
      end else begin
         for (int r = 0; r < rows; r++) begin
            e = '0; e.rd = 1'b1; e.addr = 8'(r); e.busy = 1'b1; q.push_back(e);
            for (int w = 0; w < LAT; w++) begin
               e = '0; e.busy = 1'b1; q.push_back(e);
            end
            for (int c = 0; c < NC; c++) begin
               e = '0; e.vld = 1'b1; e.col = 6'(c); e.ord = 3'((rot + r) % 8); e.busy = 1'b1;
               q.push_back(e);
            end
         end
         e = '0; e.done = 1'b1; q.push_back(e);
      end
      if (abort_idx >= 0) begin
         while (q.size() > abort_idx + 1) void'(q.pop_back());
         q.push_back('0);
      end
      q.push_back('0);
      foreach (q[i]) if (q[i].done) cnt_exp++;

      n_rd = 0; n_vld = 0; dur = -1; clk_dur = -1; n_done = 0;
      frame_rows = 8'(rows); rot_offset = 3'(rot); frame_abort = 1'b0; frame_start = 1'b1;
      step(1'b1);
      frame_start = 1'b0;
      idx = 0; clks = 0;
      cur = snap();
      check("seq", idx, match(cur, q[0]), 32'(cur), 32'(q[0]));
      if (cur.rd) n_rd++;
      if (cur.vld) n_vld++;
      if (cur.done) begin n_done++; dur = 0; clk_dur = 0; end
      while (idx < q.size() - 1) begin
         if (clks > 30000) begin
            check("timeout", idx, 1'b0, 32'(clks), 32'(q.size()));
            break;
         end
         clks++;
         case (mode)
            0:       en = 1'b1;
            1:       en = (clks % 2 == 0);
            default: en = 1'($urandom_range(0, 1));
         endcase
         frame_abort = (idx == abort_idx);
         frame_start = spur && q[idx].busy && ($urandom_range(0, 7) == 0);
         if (en && frame_start) err_exp = 1'b1;
         prev = cur;
         step(en);
         frame_start = 1'b0;
         frame_abort = 1'b0;
         cur = snap();
         if (en) begin
            idx++;
            check("seq", idx, match(cur, q[idx]), 32'(cur), 32'(q[idx]));
            if (cur.rd) n_rd++;
            if (cur.vld) n_vld++;
            if (cur.done) begin
               n_done++;
               if (dur < 0) begin dur = idx; clk_dur = clks; end
            end
         end else begin
            check("hold", idx, cur == prev, 32'(cur), 32'(prev));
         end
      end
   endtask

   task automatic check_frame(input string name, input vec_t v);
      int n_rd, n_vld, dur, clk_dur, n_done;
      run_frame(v.rows, v.rot, v.mode, v.abort_idx, v.spur, n_rd, n_vld, dur, clk_dur, n_done);
      $display("[TB] %s rows=%0d rot=%0d mode=%0d abort=%0d reads=%0d vld=%0d dur=%0d clk=%0d done=%0d",
               name, v.rows, v.rot, v.mode, v.abort_idx, n_rd, n_vld, dur, clk_dur, n_done);
      check({name, "_reads"}, v.rows, n_rd == v.exp_rd, 32'(n_rd), 32'(v.exp_rd));
      check({name, "_vld"},   v.rows, n_vld == v.exp_vld, 32'(n_vld), 32'(v.exp_vld));
      check({name, "_dur"},   v.rows, dur == v.exp_dur, 32'(dur), 32'(v.exp_dur));
      check({name, "_done"},  v.rows, n_done == v.exp_done, 32'(n_done), 32'(v.exp_done));
      if (v.exp_clk >= 0)
         check({name, "_clk"}, v.rows, clk_dur == v.exp_clk, 32'(clk_dur), 32'(v.exp_clk));
      check_status(name);
   endtask

   initial begin
      vec_t tbl[9];
      vec_t v;
      int k;
      obs_t o;

      tbl[0] = '{2,   0, 0, -1, 1'b0, 2,   90,    94,    94,    1};
      tbl[1] = '{3,   6, 0, -1, 1'b0, 3,   135,   141,   141,   1};
      tbl[2] = '{1,   3, 1, -1, 1'b0, 1,   45,    47,    94,    1};
      tbl[3] = '{1,   0, 0, 22, 1'b0, 1,   21,    -1,    -1,    0};
      tbl[4] = '{1,   5, 0, -1, 1'b0, 1,   45,    47,    47,    1};
      tbl[5] = '{0,   2, 0, -1, 1'b0, 0,   0,     0,     0,     1};
      tbl[6] = '{4,   7, 2, -1, 1'b1, 4,   180,   188,   -1,    1};
      tbl[7] = '{255, 1, 0, -1, 1'b1, 255, 11475, 11985, 11985, 1};
      tbl[8] = '{2,   4, 1, 60, 1'b0, 2,   57,    -1,    -1,    0};

      rst_n = 1'b0; fs_en = 1'b0; frame_start = 1'b0; frame_rows = '0;
      rot_offset = '0; frame_abort = 1'b0;
      @(negedge clk);
      @(negedge clk);
      o = snap();
      check("reset", 0, o == '0, 32'(o), 32'h0);
      check_status("reset");
      rst_n = 1'b1;
      step(1'b1);
      o = snap();
      check("idle", 0, o == '0, 32'(o), 32'h0);

      // Abort wins over a simultaneous start in IDLE.
      frame_rows = 8'd2; frame_start = 1'b1; frame_abort = 1'b1;
      step(1'b1);
      frame_start = 1'b0; frame_abort = 1'b0;
      o = snap();
      $display("[TB] start+abort in idle busy=%0d rd=%0d", o.busy, o.rd);
      check("start_abort", 0, o == '0, 32'(o), 32'h0);
      step(1'b1);
      o = snap();
      check("start_abort_after", 1, o == '0, 32'(o), 32'h0);

      for (int i = 0; i < 9; i++) check_frame($sformatf("vec%0d", i), tbl[i]);

      for (int i = 0; i < 6; i++) begin
         v.rows = $urandom_range(0, 5);
         v.rot  = $urandom_range(0, 7);
         v.mode = 2; v.abort_idx = -1; v.spur = 1'b1;
         v.exp_rd = v.rows; v.exp_vld = v.rows * NC;
         v.exp_dur = v.rows * (1 + LAT + NC); v.exp_clk = -1; v.exp_done = 1;
         check_frame($sformatf("rnd%0d", i), v);
      end

      // Reset in the middle of RUN clears outputs without waiting for a clock.
      frame_rows = 8'd3; rot_offset = 3'd1; frame_start = 1'b1;
      step(1'b1);
      frame_start = 1'b0;
      k = 0;
      while (!switch_vld && k < 10) begin step(1'b1); k++; end
      repeat (5) step(1'b1);
      check("pre_reset_vld", 0, switch_vld == 1'b1, 32'(switch_vld), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      o = snap();
      $display("[TB] async reset mid-run outputs=0x%0h", o);
      check("async_reset", 0, o == '0, 32'(o), 32'h0);
      err_exp = 1'b0; cnt_exp = 0;
      check_status("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1'b1);
         o = snap();
         check("post_reset_idle", i, o == '0, 32'(o), 32'h0);
      end
      check_frame("restart", tbl[4]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/switch_order_ctrl.md
SWITCH_ORDER_CTRL -- requirements
Module: switch_order_ctrl

Interface
REQ-001 Parameter RAM_LAT, default 1: RAM read latency in fs_en-qualified cycles, legal range 1..3.
REQ-002 Parameter ROW_W, default 8: width of the row address and the row count.
REQ-003 sys_clk  in  1  single clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 fs_en  in  1  symbol-rate enable; all state advances only when fs_en=1.
REQ-006 frame_start  in  1  one-cycle start request, sampled only when fs_en=1.
REQ-007 frame_rows  in  ROW_W  number of 360-bit rows in the frame, latched at accepted start.
REQ-008 rot_offset  in  3  initial rotation, latched at accepted start.
REQ-009 frame_abort  in  1  abort the current frame; sampled only when fs_en=1.
REQ-010 ram_rd_en  out  1  read strobe to the 8x45-bit bank RAM.
REQ-011 ram_rd_addr  out  ROW_W  row address.
REQ-012 switch_vld  out  1  column-select valid to the switch/order datapath.
REQ-013 switch_array  out  6  column index 0..44.
REQ-014 order_array  out  3  rotation 0..7.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_done  out  1  one fs_en-cycle pulse at the end of a frame.

Function
REQ-017 The FSM SHALL have four states, IDLE, RD, WAIT and RUN; every output is registered.
- IDLE: an accepted frame_start with frame_rows>0 goes to RD.
- RD: ram_rd_en=1 and ram_rd_addr=row for exactly one fs_en cycle, then WAIT.
- WAIT: holds for RAM_LAT fs_en cycles, then RUN.
- RUN: holds for 45 fs_en cycles with switch_vld=1 and switch_array stepping 0,1,...,44.
REQ-018 After column 44 the FSM SHALL go to RD if row+1 < frame_rows, otherwise to IDLE with a frame_done pulse.
REQ-019 order_array SHALL equal (rot_offset + row) mod 8, constant across a row, and wrap 7 to 0.
REQ-020 Each row SHALL take 1+RAM_LAT+45 fs_en cycles; the frame takes frame_rows times that.
REQ-021 When fs_en=0, all outputs and state SHALL hold and no column SHALL be skipped or repeated.
REQ-022 An accepted frame_start with frame_rows=0 SHALL produce frame_done on the next fs_en cycle, with no reads and busy staying 0.
REQ-023 frame_start while busy SHALL be ignored.
REQ-024 frame_abort SHALL take priority over frame_start and any transition: next fs_en cycle goes to IDLE with switch_vld=0, ram_rd_en=0 and no frame_done.
REQ-025 Row counter width SHALL be ROW_W; frame_rows=2^ROW_W-1 SHALL be supported without wrap.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE and every output plus internal counters = 0.
REQ-027 Reset mid-frame SHALL discard the frame; after release, only a new frame_start restarts the FSM.

Configuration
REQ-028 Macro SWITCH_ORDER_CTRL_STATUS_EN defined SHALL add two outputs, both reset to 0:
- start_err (1 bit, sticky): set by frame_start while busy, cleared only by reset.
- frame_cnt (16 bits): increments on each frame_done and wraps at 65535 to 0.
REQ-029 Without the macro, neither port nor its logic SHALL exist; all other behaviour is identical.

Structure
REQ-030 Shared package switch_order_pkg SHALL hold:
- NCOL=45;
- NBANK=8;
- the column width (6) and order width (3);
- the FSM state enum.
REQ-031 The block SHALL be a single module with no sub-module; a wrapper instantiates it together with the switch/order datapath.

Verification
REQ-032 frame_rows=2, rot_offset=0, RAM_LAT=1, fs_en=1 ->
- reads at addr 0 then 1;
- each row has 45 switch_vld cycles, switch_array 0..44, order_array 0 then 1;
- frame_done once, 94 cycles after start.
REQ-033 frame_rows=3, rot_offset=6 -> order_array 6, 7, 0 for the three rows.
REQ-034 fs_en toggling every other cycle, frame_rows=1 -> same sequence of 45 columns, duration doubled, no column skipped.
REQ-035 frame_abort at column 20 of row 0 -> next enabled cycle busy=0, switch_vld=0, no frame_done; a following start runs normally from addr 0.
REQ-036 frame_start during busy (with SWITCH_ORDER_CTRL_STATUS_EN) -> start ignored, start_err=1, frame_cnt=1 after the frame.
REQ-037 frame_rows=0 -> frame_done pulse, no ram_rd_en. rst_n low mid-RUN -> all outputs 0 immediately.
